tile_acc_sched: RTL
===================

Name: tile_acc_sched

Overview:
Controller for one output tile of the fixed-point MAC backbone.
- Sequences an accumulation: clear, then K operand beats into LANES signed 32-bit (ACC_W) accumulators.
- Drains the accumulators one lane per handshake through requantize (arithmetic right shift), 16-bit saturation (sat16 semantics) and optional ReLU.
- Sits between the operand feeder and the activation writeback stream.
- Uses the backbone_pkg types: data_t (16-bit signed), acc_t (32-bit signed).

Parameters:
LANES, 4, number of parallel accumulator lanes (power of 2, ≥2)
K_W, 10, width of the beat-count config
SHIFT_W, 5, width of the requantize shift config (0..31)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_k_len  in  K_W  number of operand beats; latched at start
cfg_shift  in  SHIFT_W  arithmetic right-shift amount; latched at start
cfg_relu  in  1  apply ReLU on drain; latched at start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE state
in_valid  in  1  operand beat valid
in_ready  out  1  high only in ACCUM
in_act  in  DATA_W  signed activation, broadcast to all lanes
in_wgt  in  LANES*DATA_W  signed weights; lane l at bits [l*16 +: 16]
out_valid  out  1  drain data valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  post-processed lane result
out_lane  out  $clog2(LANES)  lane index of out_data
out_last  out  1  high with the final lane (LANES-1)

Behaviour:
- Reset (rst=1 at posedge):
  - FSM→IDLE; all accumulators, beat and lane counters and latched config cleared.
  - busy, done, in_ready, out_valid, out_data, out_lane, out_last all 0.
  - Reset mid-operation aborts the tile silently, with no done pulse.
- States: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE: on cfg_start=1, latch cfg_*, go to CLEAR.
- CLEAR: one cycle; accumulators←0, beat counter←0. Next state is ACCUM if k_len≠0, else DRAIN.
- ACCUM:
  - in_ready=1.
  - Each handshake (in_valid & in_ready): acc[l] ← acc[l] + sext32(in_act*in_wgt[l]) for every lane l; beat counter +1.
  - Addition wraps modulo 2^32; no saturation inside the accumulator.
  - The beat that makes count = k_len moves the FSM to DRAIN on the same edge; in_ready drops the following cycle.
  - Cycles with in_valid=0 do not count.
- Latency: cfg_start at cycle t → in_ready first high at t+2.
- DRAIN:
  - out_valid=1, out_lane = lane counter (starts at 0), out_data = post(acc[out_lane]), out_last = (out_lane == LANES-1).
  - A handshake advances the lane counter. The handshake with out_last=1 goes to DONE.
  - While out_valid & !out_ready, out_data/out_lane/out_last are held stable; no lane is skipped or repeated.
- post(x), in order:
  1. s = x >>> shift (arithmetic shift, floor).
  2. Saturate s to [-32768, 32767].
  3. If relu and the result is negative, output 0.
- DONE: done=1 for exactly one cycle, busy still 1, then IDLE. cfg_start is accepted again on the cycle after DONE.
- cfg_start is ignored outside IDLE; latched config is unchanged by cfg_* inputs while busy.
- in_act/in_wgt are ignored outside ACCUM.

Optional Feature:
TILE_ACC_ROUND_EN
- Defined: when shift>0, post step 1 becomes s = (x + (1 <<< (shift-1))) >>> shift, computed at 33 bits so the bias add cannot wrap (round half up).
- Undefined: floor truncation only.
- The shift=0 path is identical in both builds.

Test Plan:
1. Basic tile: k_len=3, shift=0, relu=0, in_act=2, in_wgt={1,2,3,4} each beat → out_data 6,12,18,24 on lanes 0..3; out_last with 24; done one cycle after the last handshake.
2. Saturation/ReLU: k_len=1, act=0x7FFF, wgt={0x7FFF,0x8000,1,0}.
   - relu=0 → 0x7FFF, 0x8000, 0x7FFF, 0x0000.
   - Rerun with relu=1 → 0x7FFF, 0x0000, 0x7FFF, 0x0000.
3. Requantize: k_len=1, act=1, wgt={-5,7,6,0}.
   - shift=1 → -3, 3, 3, 0.
   - shift=2 → -2, 1, 1, 0.
   - With TILE_ACC_ROUND_EN: shift=1 → -2, 4, 3, 0; shift=2 → -1, 2, 2, 0.
4. Backpressure/gaps:
   - k_len=4 with in_valid toggling 1,0,0,1,1,0,1 → exactly 4 beats accumulated.
   - out_ready low for 3 cycles at lane 1 → out_valid held, out_data/out_lane stable, lanes 0..3 each delivered exactly once.
5. Control corners:
   - cfg_start pulsed during ACCUM with different cfg values → ignored, results match the first config.
   - rst pulsed mid-ACCUM → next cycle busy=0, in_ready=0, no done.
   - A fresh tile then produces results from zeroed accumulators.
6. k_len=0: in_ready never asserts; four outputs of 0 on lanes 0..3; done pulse; start→done takes 6 cycles with out_ready=1.

Source files
------------

// File: rtl/tile_acc_sched.sv
// tile_acc_sched: controller for one output tile of the fixed-point MAC backbone.
//   Clears LANES signed 32-bit accumulators, then accumulates cfg_k_len operand beats
//   (in_act broadcast times per-lane in_wgt). It then drains one lane per handshake
//   through arithmetic right shift, 16-bit saturation and optional ReLU.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cfg_start/k_len/shift/relu     tile start pulse and config (latched in IDLE)
//   busy, done                     status; done is a one-cycle pulse
//   in_valid/in_ready/in_act/in_wgt   operand beat stream (lane l at in_wgt[l*16 +: 16])
//   out_valid/out_ready/out_data/out_lane/out_last   drained activation stream
//
// Build option: define TILE_ACC_ROUND_EN for round-half-up requantize (shift > 0);
// the default build truncates (floor).
module tile_acc_sched #(
    parameter int LANES   = 4,
    parameter int K_W     = 10,
    parameter int SHIFT_W = 5,
    localparam int DATA_W = 16,
    localparam int ACC_W  = 32,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [K_W-1:0]          cfg_k_len,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic                    cfg_relu,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_act,
    input  logic [LANES*DATA_W-1:0] in_wgt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [LANE_W-1:0]       out_lane,
    output logic                    out_last
);

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StDone} state_e;

    localparam logic signed [ACC_W:0] SatMax = 33'sd32767;
    localparam logic signed [ACC_W:0] SatMin = -33'sd32768;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q [LANES];
    logic signed [ACC_W-1:0]   prod [LANES];
    logic [K_W-1:0]            beat_q, beat_next;
    logic [LANE_W-1:0]         lane_q;
    logic [K_W-1:0]            k_len_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic                      relu_q;
    logic                      last_lane;

    logic signed [ACC_W:0]     ext, bias, biased, shifted;
    logic [DATA_W-1:0]         sat;

    // Per-lane 16x16 signed products, sign-extended to the accumulator width.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod[l] = ACC_W'($signed(in_act)) * ACC_W'($signed(in_wgt[l*DATA_W +: DATA_W]));
        end
    end

    assign beat_next = beat_q + K_W'(1);
    assign last_lane = (lane_q == LANE_W'(LANES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            beat_q  <= '0;
            lane_q  <= '0;
            k_len_q <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        k_len_q <= cfg_k_len;
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                    end
                end
                StClear: begin
                    for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
                    beat_q <= '0;
                    lane_q <= '0;
                end
                StAccum: begin
                    if (in_valid) begin
                        // Wraps modulo 2^32 by design.
                        for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + prod[l];
                        beat_q <= beat_next;
                    end
                end
                StDrain: begin
                    if (out_ready) lane_q <= lane_q + LANE_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg_start) state_d = StClear;
            StClear: state_d = (k_len_q != '0) ? StAccum : StDrain;
            StAccum: if (in_valid && beat_next == k_len_q) state_d = StDrain;
            StDrain: if (out_ready && last_lane) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Requantize at 33 bits so the rounding bias cannot overflow.
    always_comb begin
        ext  = {acc_q[lane_q][ACC_W-1], acc_q[lane_q]};
        bias = '0;
`ifdef TILE_ACC_ROUND_EN
        if (shift_q != '0) bias[shift_q - SHIFT_W'(1)] = 1'b1;
`endif
        biased  = ext + bias;
        shifted = biased >>> shift_q;
        if (shifted > SatMax)      sat = 16'h7fff;
        else if (shifted < SatMin) sat = 16'h8000;
        else                       sat = shifted[DATA_W-1:0];
        if (relu_q && sat[DATA_W-1]) sat = '0;
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDrain);
        out_lane  = out_valid ? lane_q : '0;
        out_last  = out_valid && last_lane;
        out_data  = out_valid ? sat : '0;
    end

endmodule
